ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles a fetch may wait in AR+R before it is aborted with a timeout fault (valid range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the reset; synchronous, active-low (0 = reset).
REQ-004 pc_in  input  32  SHALL carry the current PC from the PC stage.
REQ-005 pc_valid  input  1  SHALL indicate pc_in is a fetch request.
REQ-006 pc_en  output  1  SHALL pulse high for one cycle to let the PC stage load its next value.
REQ-007 mem_arvalid / mem_arready  output / input  1 / 1  SHALL form the read-address handshake.
REQ-008 mem_araddr  output  32  SHALL carry the fetch address.
REQ-009 mem_rvalid / mem_rready  input / output  1 / 1  SHALL form the read-data handshake.
REQ-010 mem_rdata  input  32  SHALL carry the instruction word; mem_rresp  input  2  SHALL be nonzero on access error.
REQ-011 inst_valid / inst_ready  output / input  1 / 1  SHALL form the handshake to the decode stage.
REQ-012 inst, inst_pc  output  32 each  SHALL carry the fetched word and its address.
REQ-013 fault_cause  output  2  SHALL encode 00 none, 01 misaligned, 10 access error, 11 timeout.

Function
REQ-014 FSM states SHALL be IDLE, AR, R, WB; one fetch is in flight at a time.
REQ-015 IDLE, pc_valid=1, pc_in[1:0]=00: capture pc_in into fetch_pc, go to AR.
REQ-016 IDLE, pc_valid=1, pc_in[1:0]!=00: go directly to WB with inst=0, inst_pc=pc_in, fault_cause=01; no memory request is issued.
REQ-017 mem_arvalid SHALL equal (state==AR); mem_araddr SHALL equal fetch_pc and stay stable until mem_arvalid&mem_arready.
REQ-018 AR with mem_arready=1 SHALL go to R; mem_rready SHALL equal (state==R).
REQ-019 R with mem_rvalid=1 SHALL register inst=mem_rdata, inst_pc=fetch_pc, fault_cause=(mem_rresp!=0 ? 10 : 00), and go to WB.
REQ-020 inst_valid SHALL equal (state==WB); inst, inst_pc and fault_cause SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-021 WB with inst_ready=1 SHALL go to IDLE, and pc_en SHALL equal inst_valid&inst_ready, combinational, that cycle only.
REQ-022 Minimum latency: pc_valid in cycle 0, arready in 1, rvalid in 2 gives inst_valid in cycle 3.
REQ-023 An 8-bit wait counter SHALL clear on entry to AR and increment each cycle in AR or R without a completing handshake.
REQ-024 Counter==TIMEOUT with no handshake that cycle SHALL go to WB with inst=0, fault_cause=11.
REQ-025 A timeout taken in R SHALL set a drain flag; timeout in AR SHALL NOT.
REQ-026 While drain=1, the first mem_rvalid seen in state R SHALL be accepted and discarded, drain SHALL clear, and the FSM SHALL stay in R awaiting the real response.
REQ-027 pc_valid in any state other than IDLE SHALL be ignored.
REQ-028 Handshake in the same cycle as counter==TIMEOUT SHALL win; no fault is raised.

Reset
REQ-029 While rst=0: state=IDLE, inst_valid=0, pc_en=0, mem_arvalid=0, mem_rready=0, inst=0, inst_pc=0, fault_cause=00, counter=0, drain=0, fetch_pc=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the fetch with no drain; the memory side is reset by the same rst.

Structure
REQ-031 Fault cause codes, FSM state encoding and reset address 32'h8000_0000 SHALL live in the shared npc_defs package.
REQ-032 The wait counter plus timeout compare SHALL be one sub-module, ifu_wdog.

Verification
REQ-033 pc_in=0x8000_0000, arready=1 immediately, rvalid one cycle later, rdata=0x0000_0413 -> inst_valid in cycle 3, inst=0x0000_0413, fault_cause=00, one pc_en pulse.
REQ-034 inst_ready held low for 5 cycles -> inst/inst_pc stable for all 5 cycles, pc_en=0 until the cycle inst_ready=1.
REQ-035 pc_in=0x8000_0002 -> no mem_arvalid, inst_valid next cycle with fault_cause=01, inst_pc=0x8000_0002.
REQ-036 rresp=2'b10 with pc_in=0x8000_0010 -> fault_cause=10, inst_pc=0x8000_0010.
REQ-037 TIMEOUT=4, arready given but rvalid withheld -> fault_cause=11 after 4 wait cycles; a stale rvalid (rdata=0xDEAD_BEEF) during the next fetch is discarded and the following rdata is delivered.
REQ-038 rst=0 asserted in state R -> all outputs at reset values the next cycle; the next fetch completes normally.

Source files
------------

// File: rtl/npc_defs.sv
// Shared definitions for the fetch unit: FSM encoding, fault causes and
// the core reset address.
package npc_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AR   = 2'b01,
        ST_R    = 2'b10,
        ST_WB   = 2'b11
    } ifu_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ACCESS   = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          WDOG_W   = 8;

endpackage

// File: rtl/ifu_wdog.sv
// Fetch watchdog: counts wait cycles spent in AR+R and flags the cycle
// in which the budget is exhausted without a completing handshake.
module ifu_wdog
    import npc_defs::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch in flight, AXI-style read channel,
// registered result held for decode until accepted.
//
//   state   | meaning
//   IDLE    | waiting for pc_valid
//   AR      | presenting fetch_pc on the read-address channel
//   R       | waiting for read data (drain discards one stale beat first)
//   WB      | result (or fault) presented to decode
module ifu
    import npc_defs::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_en,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  fault_cause
);

    ifu_state_e  state;
    fault_e      fault_q;
    logic [31:0] fetch_pc;
    logic        drain;

    logic aligned;
    logic r_done;
    logic wd_clr;
    logic wd_run;
    logic wd_expired;

    assign aligned = (pc_in[1:0] == 2'b00);
    // A beat seen while draining belongs to an abandoned fetch.
    assign r_done  = mem_rvalid && !drain;
    assign wd_clr  = (state == ST_IDLE) && pc_valid && aligned;
    assign wd_run  = ((state == ST_AR) && !mem_arready) ||
                     ((state == ST_R) && !r_done);

    ifu_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_expired)
    );

    assign mem_arvalid = (state == ST_AR);
    assign mem_rready  = (state == ST_R);
    assign inst_valid  = (state == ST_WB);
    assign mem_araddr  = fetch_pc;
    assign pc_en       = inst_valid && inst_ready;
    assign fault_cause = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            drain    <= 1'b0;
            inst     <= '0;
            inst_pc  <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_valid) begin
                        if (aligned) begin
                            fetch_pc <= pc_in;
                            state    <= ST_AR;
                        end else begin
                            inst    <= '0;
                            inst_pc <= pc_in;
                            fault_q <= FAULT_MISALIGN;
                            state   <= ST_WB;
                        end
                    end
                end
                ST_AR: begin
                    if (mem_arready) begin
                        state <= ST_R;
                    end else if (wd_expired) begin
                        inst    <= '0;
                        inst_pc <= fetch_pc;
                        fault_q <= FAULT_TIMEOUT;
                        state   <= ST_WB;
                    end
                end
                ST_R: begin
                    if (r_done) begin
                        inst    <= mem_rdata;
                        inst_pc <= fetch_pc;
                        fault_q <= (mem_rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
                        state   <= ST_WB;
                    end else begin
                        if (mem_rvalid) begin
                            drain <= 1'b0;
                        end
                        // The request is outstanding at the memory, so its
                        // late response must be swallowed by the next fetch.
                        if (wd_expired) begin
                            inst    <= '0;
                            inst_pc <= fetch_pc;
                            fault_q <= FAULT_TIMEOUT;
                            drain   <= 1'b1;
                            state   <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (inst_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Randomised scoreboard bench for the fetch unit with a transaction-level
// reference model (wait budget, drain tracking) and a decoupled monitor.
module tb_ifu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_en;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  fault_cause;

    ifu #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_en       (pc_en),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_araddr  (mem_araddr),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fault_cause (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   pc_en_count = 0;
    int   completions = 0;
    bit   drain_pending = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Monitor: scoreboard pop on decode handshake, hold stability, pc_en rule.
    logic        prev_stall = 0;
    logic        prev_ar = 0;
    logic [31:0] prev_inst, prev_pc, prev_araddr;
    logic [1:0]  prev_fault;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(inst_valid), 32'd1);
                check("hold_inst", inst, prev_inst);
                check("hold_pc", inst_pc, prev_pc);
                check("hold_fault", 32'(fault_cause), 32'(prev_fault));
            end
            if (prev_ar) check("araddr_stable", mem_araddr, prev_araddr);
            if (mem_arvalid) check("araddr_aligned", 32'(mem_araddr[1:0]), 32'd0);
            if (inst_valid) check("pc_en_rule", 32'(pc_en), 32'(inst_ready));
            if (pc_en) pc_en_count++;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_empty: got inst %h pc %h expected no result", inst, inst_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_inst", inst, e.inst);
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_fault", 32'(fault_cause), 32'(e.fault));
                end
            end
            prev_stall  = inst_valid && !inst_ready;
            prev_ar     = mem_arvalid && !mem_arready;
            prev_inst   = inst;
            prev_pc     = inst_pc;
            prev_fault  = fault_cause;
            prev_araddr = mem_araddr;
        end else begin
            prev_stall = 0;
            prev_ar    = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            pc_valid    = 1'b0;
            pc_in       = $urandom;
            mem_arready = 1'b0;
            mem_rvalid  = 1'b0;
            inst_ready  = 1'b0;
        end
    endtask

    // One fetch: a = AR stall cycles, b = R stall cycles, stall = decode stall.
    task automatic fetch(input logic [31:0] pc, input int a, input int b, input int stall,
                         input logic [1:0] resp, input logic [31:0] word, output int lat);
        exp_t e;
        bit   stale;
        bit   done;
        bit   saw_ar;
        int   acnt, bcnt, scnt, cyc;
        stale = drain_pending;
        lat   = -1;
        if (pc[1:0] != 2'b00) begin
            e = '{32'h0, pc, 2'b01};
        end else if (a > TO) begin
            e = '{32'h0, pc, 2'b11};
        end else if (a + b + int'(stale) > TO) begin
            e = '{32'h0, pc, 2'b11};
            drain_pending = 1;
        end else begin
            e = '{word, pc, (resp != 2'b00) ? 2'b10 : 2'b00};
            drain_pending = 0;
        end
        exp_q.push_back(e);
        acnt = 0; bcnt = 0; scnt = 0; cyc = 0; done = 0; saw_ar = 0;
        while (!done && cyc < 200) begin
            step();
            pc_valid = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pc_in    = (cyc == 0) ? pc : $urandom;
            if (mem_arvalid) saw_ar = 1;
            mem_arready = mem_arvalid && (acnt == a);
            if (mem_arvalid && acnt < a) acnt++;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_rresp  = 2'($urandom);
            if (mem_rready && bcnt == b) begin
                mem_rvalid = 1'b1;
                if (stale) begin
                    mem_rdata = 32'hDEAD_BEEF;
                    mem_rresp = 2'b00;
                    stale     = 0;
                end else begin
                    mem_rdata = word;
                    mem_rresp = resp;
                    bcnt++;
                end
            end else if (mem_rready && bcnt < b) begin
                bcnt++;
            end
            if (inst_valid && lat < 0) lat = cyc;
            inst_ready = inst_valid && (scnt == stall);
            if (inst_valid && scnt < stall) scnt++;
            done = inst_valid && inst_ready;
            cyc++;
        end
        if (!done) check("fetch_bound", 32'd0, 32'd1);
        else completions++;
        if (pc[1:0] != 2'b00) check("misalign_no_ar", 32'(saw_ar), 32'd0);
    endtask

    task automatic reset_mid_fetch(input logic [31:0] pc);
        bit in_r;
        in_r = 0;
        step();
        pc_valid = 1'b1; pc_in = pc;
        mem_arready = 1'b0; mem_rvalid = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 20 && !in_r; i++) begin
            step();
            pc_valid    = 1'b0;
            in_r        = mem_rready;
            mem_arready = mem_arvalid;
        end
        check("reach_r", 32'(in_r), 32'd1);
        rst = 1'b0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        step();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_arvalid", 32'(mem_arvalid), 32'd0);
        check("rst_rready", 32'(mem_rready), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fault", 32'(fault_cause), 32'd0);
        check("rst_araddr", mem_araddr, 32'd0);
        rst = 1'b1;
        drain_pending = 0;
    endtask

    initial begin
        int lat;
        int a, b;
        logic [31:0] pc;
        rst = 1'b0; pc_valid = 1'b0; pc_in = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        inst_ready = 1'b0;
        repeat (3) step();
        check("init_inst_valid", 32'(inst_valid), 32'd0);
        check("init_arvalid", 32'(mem_arvalid), 32'd0);
        check("init_rready", 32'(mem_rready), 32'd0);
        check("init_pc_en", 32'(pc_en), 32'd0);
        check("init_inst", inst, 32'd0);
        check("init_fault", 32'(fault_cause), 32'd0);
        rst = 1'b1;
        idle(2);

        fetch(32'h8000_0000, 0, 0, 0, 2'b00, 32'h0000_0413, lat);
        check("min_latency", 32'(lat), 32'd3);
        fetch(32'h8000_0004, 0, 0, 5, 2'b00, 32'h1111_2222, lat);
        fetch(32'h8000_0002, 0, 0, 0, 2'b00, 32'h0, lat);
        check("misalign_latency", 32'(lat), 32'd1);
        fetch(32'h8000_0010, 0, 1, 0, 2'b10, 32'h3333_4444, lat);
        fetch(32'h8000_0020, TO, 0, 1, 2'b00, 32'h5555_6666, lat);
        fetch(32'h8000_0024, 0, TO, 0, 2'b00, 32'h7777_8888, lat);
        fetch(32'h8000_0028, TO + 1, 0, 0, 2'b00, 32'h0, lat);
        fetch(32'h8000_002C, 0, 0, 0, 2'b00, 32'h9999_AAAA, lat);
        fetch(32'h8000_0030, 1, 100, 2, 2'b00, 32'h0, lat);
        fetch(32'h8000_0034, 0, 0, 0, 2'b00, 32'h1234_5678, lat);
        reset_mid_fetch(32'h8000_0040);
        fetch(32'h8000_0044, 0, 0, 0, 2'b00, 32'hCAFE_0001, lat);
        check("post_reset_latency", 32'(lat), 32'd3);

        for (int i = 0; i < 80; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            if (drain_pending) begin
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3 - a);
            end else begin
                a = $urandom_range(0, 5);
                b = $urandom_range(0, 5);
            end
            fetch(pc, a, b, $urandom_range(0, 3),
                  ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                  $urandom, lat);
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("pc_en_pulses", 32'(pc_en_count), 32'(completions));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
